ex_div_ctrl: RTL
================

Name: ex_div_ctrl

Overview:
- Multi-cycle divider controller attached to the EX stage. It executes DIV and DIVU (signed and unsigned) using a radix-2 restoring algorithm, one quotient bit per cycle.
- While the divide is in progress it holds a stall request to the pipeline controller, which freezes ID/EX through the stall bus. It returns the {remainder, quotient} pair for the HI/LO write.
- EX drives start, the operands and the signed flag. EX holds these stable until ready is seen.

Parameters:
- DW, 32, operand width in bits. The counter width is derived as clog2(DW)+1.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  divide request from EX; held high until ready is observed.
- div_signed  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1  in  DW  dividend.
- opdata2  in  DW  divisor.
- annul  in  1  cancel the current op (exception/flush); takes priority over everything except reset.
- result  out  2*DW  {remainder[2DW-1:DW], quotient[DW-1:0]}, i.e. {HI, LO}.
- ready  out  1  result valid.
- stall_req  out  1  to the pipeline controller; asserted means `Stop for stages up to EX.

Behaviour:
- Reset (asynchronous, resetn=0) applies immediately, mid-operation included:
  - state=FREE, counter=0, working registers=0.
  - result=0, ready=0.
- State FREE:
  - annul=1: stay in FREE.
  - start=1 and opdata2==0: go to BYZERO.
  - start=1 and opdata2!=0: go to ON. Latch |opdata1| and |opdata2| (absolute values only when div_signed=1), div_signed, the sign of opdata1, and the XOR of the two operand signs. Clear counter.
  - Operands are sampled only here. Input changes during ON/END are ignored.
- State ON:
  - Each cycle, trial-subtract the divisor from the upper DW+1 bits of the shifted 2*DW+1 working register.
  - Non-negative trial: keep the difference and shift in quotient bit 1. Otherwise shift in 0.
  - counter increments by 1 each cycle. After DW iterations (counter==DW) go to END.
  - annul=1 in any ON cycle: go to FREE next cycle, discard work, result unchanged (0).
- State BYZERO: next cycle go to END with result=0. Division by zero is defined as result 0.
- State END:
  - result is registered. Signed sign fix-up: negate the quotient if the latched XOR is 1; negate the remainder if the dividend was negative.
  - ready=1 for as long as the state stays END.
  - start=0 or annul=1: go to FREE; ready and result return to 0.
  - start still 1: remain in END with ready=1 (covers an EX stall held from a later stage).
- Latency, from the FREE cycle in which start is sampled:
  - Nonzero divisor: ready first high DW+2 cycles later (34 for DW=32).
  - Zero divisor: ready first high 2 cycles later.
- stall_req is combinational: start & ~ready & ~annul. It is therefore high in the FREE cycle of acceptance and through ON/BYZERO, and low in END.
- Arithmetic rules:
  - Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (wraps, no trap).
  - The remainder carries the dividend's sign; the quotient truncates toward zero.
- Simultaneous events:
  - annul together with start in FREE: op not accepted, stall_req=0.
  - annul in the same cycle as the ON→END transition: go to FREE.
- State encoding is 2 bits: FREE=00, BYZERO=01, ON=10, END=11. Unreachable states are impossible with this encoding.

Decomposition:
- Into the shared defines header (alongside `Stop/`NoStop and the stall bus width):
  - DivFree, DivByZero, DivOn, DivEnd state codes.
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
  - The 2*DW result-bus width used by the EX→MEM HI/LO fields.
- One natural combinational sub-module, div_step: it takes the working register and divisor and returns the next working register plus the quotient bit. The controller FSM, counter and sign fix-up stay in ex_div_ctrl.

Test Plan:
- Unsigned divide: DIVU 100/7, start held. stall_req high for 34 cycles, then ready=1 with result={32'd2, 32'd14}. After start drops, ready=0 and result=0 next cycle.
- Signed divide: DIV -7/2 (0xFFFFFFF9/0x00000002) → result={0xFFFFFFFF, 0xFFFFFFFD}. Also 7/-2 → {0x00000001, 0xFFFFFFFD}.
- Zero divisor: DIV 5/0 → ready at cycle 2, result=0, stall_req low from cycle 2.
- Overflow wrap: signed 0x80000000/0xFFFFFFFF → {0x00000000, 0x80000000} after 34 cycles.
- Annul: annul pulse at ON cycle 10 → state FREE next cycle, ready never asserts, stall_req drops in the annul cycle. A new DIVU 9/3 accepted afterwards → {0, 3}.
- Reset and held start:
  - resetn pulled low asynchronously mid-ON (between clock edges) → ready, result and stall_req go to 0 immediately. After release with start=1, the op restarts from FREE.
  - start held 5 cycles past END → ready stays 1 and result is stable.

Source files
------------

// File: rtl/ex_div_ctrl_pkg.sv
// ============================================================================
// Module  : ex_div_ctrl_pkg
// Brief   : Shared divider state codes, handshake levels and bus widths.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package ex_div_ctrl_pkg;

    localparam int DivDW      = 32;
    localparam int DivResultW = 2 * DivDW;
    localparam int StallW     = 6;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    typedef logic [1:0] div_state_t;

endpackage

`default_nettype wire

// File: rtl/ex_div_ctrl_div_step.sv
// ============================================================================
// Module  : div_step
// Brief   : One radix-2 restoring iteration: shift, trial-subtract, restore.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module div_step
    import ex_div_ctrl_pkg::*;
#(
    parameter int DW = DivDW
) (
    input  logic [2*DW:0] work_i,
    input  logic [DW-1:0] divisor_i,
    output logic [2*DW:0] work_o,
    output logic          qbit_o
);

    logic [2*DW:0] w_shift;
    logic [DW+1:0] w_diff;

    assign w_shift = {work_i[2*DW-1:0], 1'b0};
    // One extra bit of headroom so the borrow shows up as the sign bit.
    assign w_diff  = {1'b0, w_shift[2*DW:DW]} - {2'b00, divisor_i};
    assign qbit_o  = ~w_diff[DW+1];
    assign work_o  = qbit_o ? {w_diff[DW:0], w_shift[DW-1:1], 1'b1} : w_shift;

endmodule

`default_nettype wire

// File: rtl/ex_div_ctrl.sv
// ============================================================================
// Module  : ex_div_ctrl
// Brief   : Multi-cycle signed/unsigned divider controller for the EX stage.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
#(
    parameter int DW = DivDW
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            div_signed,
    input  logic [DW-1:0]   opdata1,
    input  logic [DW-1:0]   opdata2,
    input  logic            annul,
    output logic [2*DW-1:0] result,
    output logic            ready,
    output logic            stall_req
);

    localparam int            CW      = $clog2(DW) + 1;
    localparam logic [CW-1:0] CntLast = CW'(DW);

    div_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*DW:0]   work_q, work_d;
    logic [DW-1:0]   divisor_q, divisor_d;
    logic            signed_q, signed_d;
    logic            rem_neg_q, rem_neg_d;
    logic            quo_neg_q, quo_neg_d;
    logic [2*DW-1:0] result_q, result_d;
    logic            ready_q, ready_d;

    logic [2*DW:0]   step_work;
    logic            step_qbit;
    logic [DW-1:0]   abs1, abs2, quo_fix, rem_fix;

    div_step #(.DW(DW)) u_div_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (step_work),
        .qbit_o    (step_qbit)
    );

    assign abs1 = (div_signed && opdata1[DW-1]) ? (~opdata1 + 1'b1) : opdata1;
    assign abs2 = (div_signed && opdata2[DW-1]) ? (~opdata2 + 1'b1) : opdata2;

    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    assign quo_fix = (signed_q && quo_neg_q) ? (~work_q[DW-1:0] + 1'b1) : work_q[DW-1:0];
    assign rem_fix = (signed_q && rem_neg_q) ? (~work_q[2*DW-1:DW] + 1'b1) : work_q[2*DW-1:DW];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        rem_neg_d = rem_neg_q;
        quo_neg_d = quo_neg_q;
        result_d  = '0;
        ready_d   = DivResultNotReady;
        case (state_q)
            DivFree: begin
                if (!annul && start == DivStart) begin
                    if (opdata2 == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d   = DivOn;
                        work_d    = {{(DW+1){1'b0}}, abs1};
                        divisor_d = abs2;
                        signed_d  = div_signed;
                        rem_neg_d = opdata1[DW-1];
                        quo_neg_d = opdata1[DW-1] ^ opdata2[DW-1];
                        cnt_d     = '0;
                    end
                end
            end
            DivByZero: begin
                if (annul) begin
                    state_d = DivFree;
                end else begin
                    state_d = DivEnd;
                    ready_d = DivResultReady;
                end
            end
            DivOn: begin
                if (annul) begin
                    state_d = DivFree;
                end else if (cnt_q == CntLast) begin
                    state_d  = DivEnd;
                    ready_d  = DivResultReady;
                    result_d = {rem_fix, quo_fix};
                end else begin
                    work_d = step_work;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            default: begin
                if (annul || start == DivStop) begin
                    state_d = DivFree;
                end else begin
                    ready_d  = DivResultReady;
                    result_d = result_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            rem_neg_q <= 1'b0;
            quo_neg_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            rem_neg_q <= rem_neg_d;
            quo_neg_q <= quo_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result    = result_q;
    assign ready     = ready_q;
    // Reset gating keeps the pipeline from seeing a stall while the divider is held in reset.
    assign stall_req = (resetn && start && !ready_q && !annul) ? Stop : NoStop;

endmodule

`default_nettype wire
